// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Unsigned WIDTH-bit operands; divide-by-zero finishes in one cycle.
module seq_divider #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;

  // Trial subtraction on the shifted partial remainder (quotient
  // register doubles as the dividend shift register during RUN).
  always_comb begin
    rem_sh = {remainder, quotient[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvsr};
  end

  // Control FSM plus datapath registers; all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvsr        <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            dvsr        <= divisor;
            cnt         <= '0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              quotient  <= dividend;
              remainder <= '0;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          quotient <= {quotient[WIDTH-2:0], ~trial[WIDTH]};
          if (!trial[WIDTH]) begin
            remainder <= trial[WIDTH-1:0];
          end else begin
            remainder <= rem_sh[WIDTH-1:0];
          end
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: WIDTH, default 64, operand and result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request a new division; sampled on rising clk.
REQ-005 SHALL have port: dividend  input  WIDTH  unsigned numerator; captured when start is accepted.
REQ-006 SHALL have port: divisor  input  WIDTH  unsigned denominator; captured when start is accepted.
REQ-007 SHALL have port: busy  output  1  high while iterating.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port: quotient  output  WIDTH  unsigned quotient.
REQ-010 SHALL have port: remainder  output  WIDTH  unsigned remainder.
REQ-011 SHALL have port: div_by_zero  output  1  divisor of zero in the last accepted operation.

Function
REQ-012 SHALL implement the states IDLE, RUN and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on the operation in flight.
REQ-014 On an accepted start (edge 0), SHALL capture dividend and divisor, clear div_by_zero, and ignore later input changes until the next accepted start.
REQ-015 On an accepted start with a non-zero divisor, SHALL enter RUN with busy=1 from after edge 0 through edge WIDTH.
REQ-016 SHALL use a restoring algorithm, one bit per cycle, WIDTH iterations on edges 1..WIDTH.
REQ-017 Each iteration SHALL: shift {rem, q} left by 1; compute trial = rem - divisor in WIDTH+1 bits; if trial is non-negative, set rem = trial and q[0]=1, else keep rem and set q[0]=0.
REQ-018 After edge WIDTH, SHALL be in DONE with busy=0, done=1 for exactly one cycle, and valid quotient and remainder.
REQ-019 Total latency SHALL be WIDTH cycles from the start edge to done high.
REQ-020 On an accepted start with divisor==0, SHALL skip RUN; after edge 0: done=1 (one cycle), busy=0, quotient = all ones, remainder = dividend, div_by_zero=1.
REQ-021 SHALL hold quotient, remainder and div_by_zero stable from done until the next accepted start.
REQ-022 Intermediate values on quotient and remainder during RUN SHALL be don't-care.
REQ-023 From DONE with no start, SHALL go to IDLE on the next edge; done SHALL drop and results SHALL stay held.
REQ-024 start high in the done cycle SHALL be accepted; back-to-back operations SHALL have no idle gap.
REQ-025 SHALL ensure busy and done are never high simultaneously.
REQ-026 SHALL guarantee quotient*divisor + remainder == dividend and remainder < divisor for every non-zero divisor.

Reset
REQ-027 reset_n low SHALL, immediately and independent of clk, force: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset_n rises SHALL run normally.
REQ-029 Deassertion of reset_n SHALL be effective at the first rising clk edge where reset_n is high.

Verification
REQ-030 (WIDTH=64) dividend=100, divisor=7, start one cycle -> busy high 64 cycles; done at edge 64; quotient=14, remainder=2, div_by_zero=0.
REQ-031 dividend=5, divisor=0 -> done one cycle after start, busy never high; quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=5, div_by_zero=1.
REQ-032 Boundary cases:
  - 3/10 -> quotient=0, remainder=3.
  - 0xFFFF_FFFF_FFFF_FFFF/1 -> quotient=all ones, remainder=0.
  - 0xFFFF_FFFF_FFFF_FFFF/0xFFFF_FFFF_FFFF_FFFF -> quotient=1, remainder=0.
REQ-033 Start 1000/3; at cycle 10 pulse start with 8/2 and change the operand inputs -> second request ignored; result quotient=333, remainder=1.
REQ-034 Start 1000/3, assert reset_n low at cycle 30 -> all outputs 0 asynchronously, no done; release, then start 9/4 -> quotient=2, remainder=1 after 64 cycles.
REQ-035 Back-to-back: start 50/5, then assert start in the done cycle with 7/2 -> first quotient=10, remainder=0; second quotient=3, remainder=1 exactly 64 cycles later.
REQ-036 Randomized check: 10k random pairs including zero divisors -> REQ-020 and REQ-026 hold; busy/done exclusivity holds every cycle.
